execute_stage: RTL and testbench

EXECUTE_STAGE -- requirements
Module: execute_stage

---
 rtl/execute_stage.sv | 123 ++++++++++++
 tb/tb_execute_stage.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// Pipeline EX stage: forwarding muxes, 16-op ALU, destination select and the
// EX/MEM register with flush-over-stall priority.
module execute_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic [31:0] imm,
  input  logic [4:0]  shamt,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [3:0]  alu_op,
  input  logic        alu_src,
  input  logic        reg_dst,
  input  logic        regF_wr,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic        mem_to_reg,
  input  logic [1:0]  control_muxA,
  input  logic [1:0]  control_muxB,
  input  logic [31:0] MEM_alu_result,
  input  logic [31:0] WB_write_data,
  output logic [31:0] out_alu_result,
  output logic [31:0] out_store_data,
  output logic [4:0]  out_rd,
  output logic        out_regF_wr,
  output logic        out_mem_rd,
  output logic        out_mem_wr,
  output logic        out_mem_to_reg,
  output logic        out_zero
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000, OP_SUB  = 4'b0001, OP_AND  = 4'b0010, OP_OR   = 4'b0011,
    OP_XOR  = 4'b0100, OP_NOR  = 4'b0101, OP_SLT  = 4'b0110, OP_SLTU = 4'b0111,
    OP_SLL  = 4'b1000, OP_SRL  = 4'b1001, OP_SRA  = 4'b1010, OP_SLLV = 4'b1011,
    OP_SRLV = 4'b1100, OP_SRAV = 4'b1101, OP_LUI  = 4'b1110, OP_PASS = 4'b1111
  } alu_op_e;

  logic [31:0] op_a;
  logic [31:0] fwd_b;
  logic [31:0] alu_b;
  logic [31:0] alu_result;
  logic [4:0]  dest;

  // Select 10 is the younger EX/MEM value, 01 the older MEM/WB value.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    op_a  = rs_data;
    fwd_b = rt_data;
    case (control_muxA)
      2'b10:   op_a = MEM_alu_result;
      2'b01:   op_a = WB_write_data;
      default: op_a = rs_data;
    endcase
    case (control_muxB)
      2'b10:   fwd_b = MEM_alu_result;
      2'b01:   fwd_b = WB_write_data;
      default: fwd_b = rt_data;
    endcase
    alu_b = alu_src ? imm : fwd_b;
    dest  = reg_dst ? rd : rt;
  end

  always_comb begin
    alu_result = 32'h0;
    case (alu_op_e'(alu_op))
      OP_ADD:  alu_result = op_a + alu_b;
      OP_SUB:  alu_result = op_a - alu_b;
      OP_AND:  alu_result = op_a & alu_b;
      OP_OR:   alu_result = op_a | alu_b;
      OP_XOR:  alu_result = op_a ^ alu_b;
      OP_NOR:  alu_result = ~(op_a | alu_b);
      OP_SLT:  alu_result = {31'h0, $signed(op_a) < $signed(alu_b)};
      OP_SLTU: alu_result = {31'h0, op_a < alu_b};
      OP_SLL:  alu_result = alu_b << shamt;
      OP_SRL:  alu_result = alu_b >> shamt;
      OP_SRA:  alu_result = $signed(alu_b) >>> shamt;
      OP_SLLV: alu_result = alu_b << op_a[4:0];
      OP_SRLV: alu_result = alu_b >> op_a[4:0];
      OP_SRAV: alu_result = $signed(alu_b) >>> op_a[4:0];
      OP_LUI:  alu_result = {alu_b[15:0], 16'h0};
      OP_PASS: alu_result = op_a;
      default: alu_result = 32'h0;
    endcase
  end

  // A flush inserts a bubble even while stalled: the squashed instruction must not commit.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      out_alu_result <= '0;
      out_store_data <= '0;
      out_rd         <= '0;
      out_regF_wr    <= 1'b0;
      out_mem_rd     <= 1'b0;
      out_mem_wr     <= 1'b0;
      out_mem_to_reg <= 1'b0;
      out_zero       <= 1'b0;
    end else if (flush) begin
      out_alu_result <= '0;
      out_store_data <= '0;
      out_rd         <= '0;
      out_regF_wr    <= 1'b0;
      out_mem_rd     <= 1'b0;
      out_mem_wr     <= 1'b0;
      out_mem_to_reg <= 1'b0;
      out_zero       <= 1'b0;
    end else if (!stall) begin
      out_alu_result <= alu_result;
      out_store_data <= fwd_b;
      out_rd         <= dest;
      out_regF_wr    <= regF_wr;
      out_mem_rd     <= mem_rd;
      out_mem_wr     <= mem_wr;
      out_mem_to_reg <= mem_to_reg;
      out_zero       <= (alu_result == 32'h0);
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: forwarding, ALU ops, stall, flush and async reset.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic [31:0] rs_data, rt_data, imm;
  logic [4:0]  shamt, rt, rd;
  logic [3:0]  alu_op;
  logic        alu_src, reg_dst, regF_wr, mem_rd, mem_wr, mem_to_reg;
  logic [1:0]  control_muxA, control_muxB;
  logic [31:0] MEM_alu_result, WB_write_data;
  logic [31:0] out_alu_result, out_store_data;
  logic [4:0]  out_rd;
  logic        out_regF_wr, out_mem_rd, out_mem_wr, out_mem_to_reg, out_zero;

  int vectors = 0;
  int miscompares = 0;

  execute_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .rs_data(rs_data), .rt_data(rt_data), .imm(imm), .shamt(shamt),
    .rt(rt), .rd(rd), .alu_op(alu_op), .alu_src(alu_src), .reg_dst(reg_dst),
    .regF_wr(regF_wr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_to_reg(mem_to_reg),
    .control_muxA(control_muxA), .control_muxB(control_muxB),
    .MEM_alu_result(MEM_alu_result), .WB_write_data(WB_write_data),
    .out_alu_result(out_alu_result), .out_store_data(out_store_data),
    .out_rd(out_rd), .out_regF_wr(out_regF_wr), .out_mem_rd(out_mem_rd),
    .out_mem_wr(out_mem_wr), .out_mem_to_reg(out_mem_to_reg), .out_zero(out_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100000 time units");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic check_data(input string tag, input logic [31:0] alu, input logic [31:0] store,
                            input logic [4:0] dst, input logic zero);
    check({tag, ".alu"},   out_alu_result, alu);
    check({tag, ".store"}, out_store_data, store);
    check({tag, ".rd"},    {27'h0, out_rd}, {27'h0, dst});
    check({tag, ".zero"},  {31'h0, out_zero}, {31'h0, zero});
  endtask

  task automatic check_ctrl(input string tag, input logic [3:0] ctrl);
    check({tag, ".ctrl"}, {28'h0, out_regF_wr, out_mem_rd, out_mem_wr, out_mem_to_reg},
          {28'h0, ctrl});
  endtask

  task automatic clear_inputs();
    stall = 0; flush = 0;
    rs_data = 0; rt_data = 0; imm = 0; shamt = 0; rt = 0; rd = 0;
    alu_op = 4'b0000; alu_src = 0; reg_dst = 0;
    regF_wr = 0; mem_rd = 0; mem_wr = 0; mem_to_reg = 0;
    control_muxA = 2'b00; control_muxB = 2'b00;
    MEM_alu_result = 0; WB_write_data = 0;
  endtask

  // Outputs are sampled 1 time unit after the rising edge; inputs change there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    #2;
    check_data("reset", 32'h0, 32'h0, 5'd0, 1'b0);
    check_ctrl("reset", 4'b0000);
    tick();

    // Forwarding: A from MEM (100), B from WB (7).
    rst = 0;
    rs_data = 5; rt_data = 3; MEM_alu_result = 100; WB_write_data = 7;
    control_muxA = 2'b10; control_muxB = 2'b01;
    rd = 9; reg_dst = 1; regF_wr = 1;
    tick();
    check_data("fwd", 32'd107, 32'd7, 5'd9, 1'b0);
    check_ctrl("fwd", 4'b1000);

    control_muxA = 2'b11; control_muxB = 2'b11;
    tick();
    check_data("sel11", 32'd8, 32'd3, 5'd9, 1'b0);

    // Immediate as B; store data still takes the register operand.
    clear_inputs();
    rs_data = 1; rt_data = 32'h55; imm = 32'hFFFF_FFFF; alu_src = 1; rt = 5'd17;
    tick();
    check_data("imm", 32'h0, 32'h55, 5'd17, 1'b1);

    clear_inputs();
    rs_data = 32'hFFFF_FFFF; rt_data = 1; alu_op = 4'b0110;
    tick();
    check("slt", out_alu_result, 32'd1);
    alu_op = 4'b0111;
    tick();
    check("sltu", out_alu_result, 32'd0);

    rt_data = 32'h8000_0000; shamt = 4; alu_op = 4'b1010;
    tick();
    check("sra", out_alu_result, 32'hF800_0000);

    rs_data = 36; rt_data = 32'h1234_5670; alu_op = 4'b1100;
    tick();
    check("srlv", out_alu_result, 32'h0123_4567);

    rs_data = 3; rt_data = 5; alu_op = 4'b0001;
    tick();
    check("sub", out_alu_result, 32'hFFFF_FFFE);

    rs_data = 32'hF0F0_F0F0; rt_data = 32'h0F0F_0000; alu_op = 4'b0101;
    tick();
    check("nor", out_alu_result, 32'h0000_0F0F);

    rt_data = 32'h0000_1234; alu_op = 4'b1110;
    tick();
    check("lui", out_alu_result, 32'h1234_0000);

    rt_data = 1; shamt = 31; alu_op = 4'b1000;
    tick();
    check("sll", out_alu_result, 32'h8000_0000);

    rs_data = 32'hDEAD_BEEF; alu_op = 4'b1111;
    tick();
    check("pass", out_alu_result, 32'hDEAD_BEEF);

    // Stall: load 10+20, then hold for three edges while every input moves.
    clear_inputs();
    rs_data = 10; rt_data = 20; rd = 3; reg_dst = 1; mem_rd = 1; mem_to_reg = 1;
    tick();
    check_data("load", 32'd30, 32'd20, 5'd3, 1'b0);
    check_ctrl("load", 4'b0101);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      rs_data = 999 + i; rt_data = 1; rd = 7; alu_op = 4'b0001;
      regF_wr = 1; mem_rd = 0; mem_wr = 1; mem_to_reg = 0;
      tick();
      check_data($sformatf("stall%0d", i), 32'd30, 32'd20, 5'd3, 1'b0);
      check_ctrl($sformatf("stall%0d", i), 4'b0101);
    end
    stall = 0;
    rs_data = 999;
    tick();
    check_data("unstall", 32'd998, 32'd1, 5'd7, 1'b0);
    check_ctrl("unstall", 4'b1010);

    // Async reset between edges during a stall discards held contents.
    stall = 1;
    rs_data = 2; rt_data = 2; alu_op = 4'b0000;
    #2;
    rst = 1;
    #1;
    check_data("async_rst", 32'h0, 32'h0, 5'd0, 1'b0);
    check_ctrl("async_rst", 4'b0000);
    #1;
    rst = 0;
    stall = 0;
    tick();
    check_data("post_rst", 32'd4, 32'd2, 5'd7, 1'b0);
    check_ctrl("post_rst", 4'b1010);

    // Flush beats stall.
    clear_inputs();
    rs_data = 1; rt_data = 2; rd = 5; reg_dst = 1; regF_wr = 1; mem_wr = 1;
    tick();
    check_data("preflush", 32'd3, 32'd2, 5'd5, 1'b0);
    flush = 1; stall = 1;
    tick();
    check("flush.alu",   out_alu_result, 32'h0);
    check("flush.store", out_store_data, 32'h0);
    check("flush.rd",    {27'h0, out_rd}, 32'h0);
    check_ctrl("flush", 4'b0000);
    flush = 0; stall = 0;
    tick();
    check_data("postflush", 32'd3, 32'd2, 5'd5, 1'b0);
    check_ctrl("postflush", 4'b1010);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
